// File: rtl/msrv32_ahb_pkg.sv
// Shared AHB-Lite encodings and the data-slave state type for the msrv32 data port responder.
package msrv32_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_t;

endpackage

// File: rtl/msrv32_bytewr_ram.sv
// Word-organised RAM with four byte-lane write enables: synchronous write, asynchronous read.
module msrv32_bytewr_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/msrv32_ahb_data_slave.sv
// AHB-Lite data-memory responder for the msrv32 core with programmable wait states.
// Define MSRV32_DSLAVE_ERR_EN to give out-of-range or misaligned transfers a two-cycle ERROR response.
module msrv32_ahb_data_slave
    import msrv32_ahb_pkg::*;
#(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          WAIT_CNT  = 0
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_in,
    input  logic        ms_riscv32_mp_dmwr_req_in,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
    input  logic [1:0]  ms_riscv32_mp_data_htrans_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    output logic [31:0] ms_riscv32_mp_data_out,
    output logic        ms_riscv32_mp_data_hready_out,
    output logic        ms_riscv32_mp_hresp_out
);

    localparam int         AW        = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CNT - 1);

    slave_state_t  state;
    logic [3:0]    wait_q;
    logic [AW-1:0] index_q;
    logic          write_q;
    logic [3:0]    mask_q;
    logic          active_q;
    logic          hready_q;

    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          capture;
    logic          addr_err;
    logic          complete;
    logic [31:0]   ram_rdata;

    assign offset  = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
    assign index   = offset[AW+1:2];
    assign capture = hready_q &&
                     ((ms_riscv32_mp_data_htrans_in == HTRANS_NONSEQ) ||
                      (ms_riscv32_mp_data_htrans_in == HTRANS_SEQ));

`ifdef MSRV32_DSLAVE_ERR_EN
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;

    logic hresp_q;
    logic unused_offset_bits;

    // Addresses below the base wrap to huge offsets, so one unsigned compare covers both bounds.
    assign addr_err = ({1'b0, offset} >= MEM_BYTES) || (ms_riscv32_mp_dmaddr_in[1:0] != 2'b00);
    assign unused_offset_bits = ^offset[1:0];
    assign ms_riscv32_mp_hresp_out = hresp_q;
`else
    logic unused_offset_bits;

    assign addr_err = 1'b0;
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
    assign ms_riscv32_mp_hresp_out = HRESP_OKAY;
`endif

    // A captured legal transfer stays active until the cycle in which hready is high again.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state    <= ST_IDLE;
            wait_q   <= '0;
            index_q  <= '0;
            write_q  <= 1'b0;
            mask_q   <= '0;
            active_q <= 1'b0;
            hready_q <= 1'b1;
`ifdef MSRV32_DSLAVE_ERR_EN
            hresp_q  <= HRESP_OKAY;
`endif
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_q == 4'd0) begin
                        state    <= ST_IDLE;
                        hready_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
`ifdef MSRV32_DSLAVE_ERR_EN
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
`endif
                default: begin
                    // IDLE and ERR2 both present hready=1, so both may accept a new address phase.
                    state    <= ST_IDLE;
                    active_q <= 1'b0;
                    hready_q <= 1'b1;
`ifdef MSRV32_DSLAVE_ERR_EN
                    hresp_q  <= HRESP_OKAY;
`endif
                    if (capture) begin
                        index_q <= index;
                        write_q <= ms_riscv32_mp_dmwr_req_in;
                        mask_q  <= ms_riscv32_mp_dmwr_mask_in;
                        if (addr_err) begin
                            state    <= ST_ERR1;
                            hready_q <= 1'b0;
`ifdef MSRV32_DSLAVE_ERR_EN
                            hresp_q  <= HRESP_ERROR;
`endif
                        end else begin
                            active_q <= 1'b1;
                            if (WAIT_CNT > 0) begin
                                state    <= ST_WAIT;
                                wait_q   <= WAIT_LOAD;
                                hready_q <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign complete = active_q && hready_q;

    msrv32_bytewr_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (ms_riscv32_mp_clk_in),
        .we    (complete && write_q),
        .be    (mask_q),
        .addr  (index_q),
        .wdata (ms_riscv32_mp_dmdata_in),
        .rdata (ram_rdata)
    );

    assign ms_riscv32_mp_data_out        = (complete && !write_q) ? ram_rdata : 32'h0;
    assign ms_riscv32_mp_data_hready_out = hready_q;

endmodule

// File: doc/msrv32_ahb_data_slave.md
# msrv32_ahb_data_slave

AHB-Lite responder for the msrv32 core's data port: a word-organised, byte-writable data memory with a programmable wait-state count and optional error response. It sits on the far side of the core's data memory interface in the test and integration environment. It answers every address/data-phase transfer the core issues with `hready` and `hresp`, and with read data for reads.

## Interface
Parameters:
- `MEM_DEPTH`, 1024: memory size in 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h0001_0000: byte address of word 0.
- `WAIT_CNT`, 0: wait states inserted in every OKAY data phase; range 0..15.

Ports:
- `ms_riscv32_mp_clk_in`, in, 1: clock; all state changes on the rising edge.
- `ms_riscv32_mp_rst_in`, in, 1: reset, asynchronous, active-high.
- `ms_riscv32_mp_dmaddr_in`, in, 32: HADDR from the core.
- `ms_riscv32_mp_dmwr_req_in`, in, 1: HWRITE; 1 means write.
- `ms_riscv32_mp_dmwr_mask_in`, in, 4: byte strobes; bit i enables byte lane i.
- `ms_riscv32_mp_data_htrans_in`, in, 2: HTRANS, with IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `ms_riscv32_mp_dmdata_in`, in, 32: HWDATA, valid in the data phase.
- `ms_riscv32_mp_data_out`, out, 32: HRDATA.
- `ms_riscv32_mp_data_hready_out`, out, 1: HREADY.
- `ms_riscv32_mp_hresp_out`, out, 1: HRESP; 0 means OKAY, 1 means ERROR.

## Operation
- **Address-phase capture.** The address phase is sampled on a rising edge where `hready_out`=1 and `htrans` is NONSEQ or SEQ.
- **Registered fields.** A captured address phase registers the word index, write flag, mask and error flag.
- **IDLE/BUSY transfers.** These are not captured. The next cycle is a zero-wait OKAY.
- **Word index.** Computed as `(haddr - BASE_ADDR) >> 2`, truncated to log2(`MEM_DEPTH`) bits. `haddr[1:0]` is ignored.
- **State machine states:** IDLE, WAIT, ERR1, ERR2.
  - IDLE: no data phase is pending, or a pending phase completes this cycle.
  - IDLE to WAIT: capture of a legal transfer when `WAIT_CNT`>0. The wait counter loads `WAIT_CNT`-1.
  - WAIT: `hready_out`=0. The counter decrements each cycle.
  - WAIT to IDLE: when the counter is 0. That cycle completes with `hready_out`=1.
  - With `WAIT_CNT`=0, a legal transfer completes in the cycle after capture.
  - IDLE to ERR1: capture of an errored transfer (see Configuration).
  - ERR1: `hready_out`=0, `hresp_out`=1. Always followed by ERR2.
  - ERR2: `hready_out`=1, `hresp_out`=1. Returns to IDLE, or captures a new address phase.
- **Writes.** Bytes whose mask bit is set are written from `dmdata_in` on the rising edge ending the completing data-phase cycle. Unmasked bytes are unchanged.
- **Reads.** `data_out` is `mem[index_q]` combinationally while in a read data phase. In every other cycle, including wait and error cycles, it is 0.
- **Errored transfers.** An errored write never modifies memory. An errored read returns 0.
- **Write-then-read.** A read of the word just written, issued back to back, returns the new data. No forwarding is needed, because the write commits before the read data phase.
- **Reset.** Reset asserted at any time, including mid-wait or mid-error, forces:
  - state to IDLE;
  - the pending transfer to be discarded, and its write not committed;
  - outputs to `hready_out`=1, `hresp_out`=0, `data_out`=0.
- **Memory contents.** Not reset.

## Timing
- Address phase in cycle N.
- OKAY completion in cycle N+1+`WAIT_CNT`.
- Error response: ERR1 in cycle N+1, ERR2 in cycle N+2.
- A new address phase may be captured in the completing cycle, whether OKAY or ERR2. This gives full pipelining, one transfer per cycle when `WAIT_CNT`=0.
- `hready_out` and `hresp_out` are registered.
- `data_out` is combinational from the registered index.

## Configuration
- **Macro:** `MSRV32_DSLAVE_ERR_EN`.
- **Defined:**
  - A transfer whose address is outside [`BASE_ADDR`, `BASE_ADDR`+4*`MEM_DEPTH`) is errored.
  - A transfer with `haddr[1:0]`≠0 is also errored.
  - Errored transfers take the two-cycle ERROR response and ignore `WAIT_CNT`.
- **Undefined:**
  - No transfer is errored, and the index wraps modulo `MEM_DEPTH`.
  - `hresp_out` is tied to 0, and ERR1/ERR2 are absent.

## Structure
- **Shared package `msrv32_ahb_pkg`:**
  - HTRANS encodings;
  - HRESP OKAY/ERROR constants;
  - the slave state enum.
- **Sub-module `msrv32_bytewr_ram`:** a synchronous-write, asynchronous-read, 4-lane byte-enable RAM holding the array.
- The FSM, wait counter and error decode stay in the top module.

## Test plan
- Reset with `WAIT_CNT`=0: `hready_out`=1, `hresp_out`=0, `data_out`=0. Write 0xDEADBEEF with mask 4'hF to `BASE_ADDR`+8, then read it back to back; the read data phase returns 0xDEADBEEF, and no cycle has `hready`=0.
- Partial write: write mask 4'b0101 with data 0x11223344 over word 0xFFFFFFFF; a read returns 0xFF22FF44.
- `WAIT_CNT`=3 read: `hready_out` is low for exactly 3 cycles after the address phase, then high with the data. An IDLE `htrans` during the wait changes nothing.
- With `MSRV32_DSLAVE_ERR_EN`, a write to `BASE_ADDR`+4*`MEM_DEPTH`: cycle N+1 has `hready`=0/`hresp`=1, cycle N+2 has 1/1. Memory at index 0 is unchanged. A NONSEQ captured in ERR2 completes OKAY.
- Reset asserted during the 2nd wait cycle of a write: outputs return immediately to their reset values, and a following read of that word returns the old value.
